// File: rtl/i2c_wr_sched_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared definitions for the I2C register-write scheduler: FSM state
//   encoding, write-frame constants and the byte selector that turns a
//   latched {dev, reg, data} request into the byte sent for a given index.
// ---------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_FIN  = 2'd3
   } wr_state_t;

   localparam logic        I2C_WR_BIT   = 1'b0;
   localparam int unsigned BYTES_PER_WR = 3;
   localparam int unsigned BIDX_W       = 2;

   // Byte 0 is the address byte with the write bit appended.
   function automatic logic [7:0] wr_byte(
      input logic [6:0]        dev,
      input logic [7:0]        rg,
      input logic [7:0]        dat,
      input logic [BIDX_W-1:0] bidx
   );
      case (bidx)
         2'd0:    wr_byte = {dev, I2C_WR_BIT};
         2'd1:    wr_byte = rg;
         default: wr_byte = dat;
      endcase
   endfunction

endpackage

// File: rtl/i2c_wr_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
//   Purely combinational round-robin picker. Searches the request vector
//   starting at i_ptr and wrapping, returns the first requester found.
// Ports
//   i_req  [NREQ]   request vector
//   i_ptr  [IDX_W]  search start index (must be < NREQ)
//   o_gnt  [NREQ]   one-hot grant (all zero if no request)
//   o_idx  [IDX_W]  index of granted requester
//   o_any           at least one request present
// ---------------------------------------------------------------------------
module rr_arb
   import i2c_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [31:0]      w_sum;
   logic [IDX_W-1:0] w_c;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_sum = '0;
      w_c   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         // Candidate index (ptr + k) mod NREQ without a divider.
         w_sum = 32'(i_ptr) + k;
         w_c   = IDX_W'((w_sum >= NREQ) ? (w_sum - NREQ) : w_sum);
         if (!o_any && i_req[w_c]) begin
            o_any      = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_idx      = w_c;
         end
      end
   end

endmodule

// File: rtl/i2c_wr_sched.sv
// ---------------------------------------------------------------------------
// i2c_wr_sched
//   Sequences 3-byte I2C register writes ({dev,W}, reg, data) into a shared
//   byte-send engine, arbitrating round-robin between NREQ requesters.
//   A watchdog bounds the wait for each byte's ack phase.
// Ports
//   clk, rst_n               engine 2x i2c clock, async active-low reset
//   req_valid [NREQ]         per-requester write request, held until ready
//   req_dev   [7*NREQ]       device address, slice i = requester i
//   req_reg   [8*NREQ]       register address
//   req_data  [8*NREQ]       register data
//   req_ready [NREQ]         one-hot 1-cycle accept pulse
//   done, err, done_id [3]   transaction finished / NACK-or-timeout / index
//   eng_ready, eng_data [8]  byte-load pulse and byte to the engine
//   eng_done, eng_nack       engine ack phase level and NACK flag
// ---------------------------------------------------------------------------
module i2c_wr_sched
   import i2c_pkg::*;
#(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned TO_CYC = 1024,
   parameter int unsigned TO_W   = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [7*NREQ-1:0] req_dev,
   input  logic [8*NREQ-1:0] req_reg,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              done,
   output logic              err,
   output logic [2:0]        done_id,
   output logic              eng_ready,
   output logic [7:0]        eng_data,
   input  logic              eng_done,
   input  logic              eng_nack
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   wr_state_t         r_state, w_state_nxt;

   logic [NREQ-1:0]   w_gnt;
   logic [IDX_W-1:0]  w_idx;
   logic              w_any;
   logic [IDX_W-1:0]  w_ptr_nxt;

   logic [IDX_W-1:0]  r_rr_ptr;
   logic [IDX_W-1:0]  r_idx;
   logic [6:0]        r_dev;
   logic [7:0]        r_reg;
   logic [7:0]        r_data;
   logic [BIDX_W-1:0] r_bidx;
   logic [TO_W-1:0]   r_wdog;

   logic              r_done_s1, r_done_s2, r_nack_s1;
   logic              w_rise, w_last, w_wd_exp;
   logic              w_take, w_adv, w_fin, w_fin_err;

   logic [6:0]        w_dev;
   logic [7:0]        w_reg;
   logic [7:0]        w_data;

   logic [NREQ-1:0]   r_req_ready;
   logic              r_done, r_err;
   logic [2:0]        r_done_id;
   logic              r_eng_ready;
   logic [7:0]        r_eng_data;

   rr_arb #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_ptr_nxt = (32'(w_idx) == NREQ - 1) ? '0 : IDX_W'(w_idx + 1'b1);

   // eng_done is registered once before edge detection; eng_nack is taken
   // through the same stage so it is the value seen with the rising edge.
   assign w_rise = r_done_s1 & ~r_done_s2;
   assign w_last = (r_bidx == BIDX_W'(BYTES_PER_WR - 1));

   // Payload of the granted requester via one-hot AND-OR.
   always_comb begin
      w_dev  = '0;
      w_reg  = '0;
      w_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_dev  = w_dev  | (req_dev [i*7 +: 7] & {7{w_gnt[i]}});
         w_reg  = w_reg  | (req_reg [i*8 +: 8] & {8{w_gnt[i]}});
         w_data = w_data | (req_data[i*8 +: 8] & {8{w_gnt[i]}});
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_adv       = 1'b0;
      w_fin       = 1'b0;
      w_fin_err   = 1'b0;
      w_wd_exp    = (r_wdog == TO_W'(TO_CYC - 1));
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_take      = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // An ack edge takes priority over the watchdog; a NACK always
            // reports an error, so NACK+timeout yields one errored done.
            if (w_rise && r_nack_s1) begin
               w_fin       = 1'b1;
               w_fin_err   = 1'b1;
               w_state_nxt = ST_FIN;
            end else if (w_rise && w_last) begin
               w_fin       = 1'b1;
               w_state_nxt = ST_FIN;
            end else if (w_rise) begin
               w_adv       = 1'b1;
               w_state_nxt = ST_LOAD;
            end else if (w_wd_exp) begin
               w_fin       = 1'b1;
               w_fin_err   = 1'b1;
               w_state_nxt = ST_FIN;
            end
         end
         ST_FIN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_s1   <= 1'b0;
         r_done_s2   <= 1'b0;
         r_nack_s1   <= 1'b0;
         r_rr_ptr    <= '0;
         r_idx       <= '0;
         r_dev       <= '0;
         r_reg       <= '0;
         r_data      <= '0;
         r_bidx      <= '0;
         r_wdog      <= '0;
         r_req_ready <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_done_id   <= '0;
         r_eng_ready <= 1'b0;
         r_eng_data  <= '1;
      end else begin
         r_done_s1   <= eng_done;
         r_done_s2   <= r_done_s1;
         r_nack_s1   <= eng_nack;

         r_req_ready <= w_take ? w_gnt : '0;
         if (w_take) begin
            r_dev    <= w_dev;
            r_reg    <= w_reg;
            r_data   <= w_data;
            r_idx    <= w_idx;
            r_rr_ptr <= w_ptr_nxt;
            r_bidx   <= '0;
         end else if (w_adv) begin
            r_bidx   <= r_bidx + 1'b1;
         end

         r_eng_ready <= (r_state == ST_LOAD);
         if (r_state == ST_LOAD) begin
            r_eng_data <= wr_byte(r_dev, r_reg, r_data, r_bidx);
            r_wdog     <= '0;
         end else if (r_state == ST_WAIT) begin
            r_wdog     <= r_wdog + 1'b1;
         end

         r_done <= w_fin;
         if (w_fin) begin
            r_err     <= w_fin_err;
            r_done_id <= 3'(r_idx);
         end else begin
            r_err     <= 1'b0;
         end
      end
   end

   assign req_ready = r_req_ready;
   assign done      = r_done;
   assign err       = r_err;
   assign done_id   = r_done_id;
   assign eng_ready = r_eng_ready;
   assign eng_data  = r_eng_data;

endmodule

// File: tb/tb_i2c_wr_sched.sv
module tb_i2c_wr_sched;

   localparam int unsigned NREQ = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [7*NREQ-1:0] req_dev;
   logic [8*NREQ-1:0] req_reg;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              done, err;
   logic [2:0]        done_id;
   logic              eng_ready;
   logic [7:0]        eng_data;
   logic              eng_done, eng_nack;

   int vec;
   int errs;

   logic [7:0]      byte_log[$];
   time             er_t[$];
   logic [NREQ-1:0] gnt_log[$];
   time             gnt_t[$];
   logic [2:0]      id_log[$];
   logic            err_log[$];
   time             done_t[$];
   time             rise_t;

   logic            eng_auto;
   logic            nack_en;
   logic [7:0]      nack_val;

   i2c_wr_sched #(
      .NREQ   (NREQ),
      .TO_CYC (64),
      .TO_W   (7)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_dev   (req_dev),
      .req_reg   (req_reg),
      .req_data  (req_data),
      .req_ready (req_ready),
      .done      (done),
      .err       (err),
      .done_id   (done_id),
      .eng_ready (eng_ready),
      .eng_data  (eng_data),
      .eng_done  (eng_done),
      .eng_nack  (eng_nack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor and requester behaviour: record outputs, drop valid on accept.
   initial begin
      forever begin
         @(negedge clk);
         if (eng_ready) begin
            byte_log.push_back(eng_data);
            er_t.push_back($time);
         end
         if (req_ready != '0) begin
            gnt_log.push_back(req_ready);
            gnt_t.push_back($time);
            req_valid = req_valid & ~req_ready;
         end
         if (done) begin
            id_log.push_back(done_id);
            err_log.push_back(err);
            done_t.push_back($time);
         end
      end
   end

   // Engine model: ack phase starts 3 cycles after a byte load, lasts 2.
   initial begin
      eng_done = 1'b0;
      eng_nack = 1'b0;
      forever begin
         @(negedge clk);
         if (eng_auto && eng_ready) begin
            repeat (3) @(negedge clk);
            eng_nack = nack_en && (eng_data == nack_val);
            eng_done = 1'b1;
            rise_t   = $time;
            repeat (2) @(negedge clk);
            eng_done = 1'b0;
            eng_nack = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_logs;
      byte_log.delete();
      er_t.delete();
      gnt_log.delete();
      gnt_t.delete();
      id_log.delete();
      err_log.delete();
      done_t.delete();
   endtask

   task automatic apply_reset;
      rst_n     = 1'b0;
      req_valid = '0;
      eng_auto  = 1'b1;
      nack_en   = 1'b0;
      nack_val  = 8'h00;
      eng_done  = 1'b0;
      eng_nack  = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      clear_logs();
   endtask

   task automatic wait_done(input int n_done, input int budget, input string name);
      int k;
      k = 0;
      while (done_t.size() < n_done && k < budget) begin
         tick(1);
         k++;
      end
      vec++;
      if (done_t.size() < n_done) begin
         errs++;
         $display("FAIL %s: timeout, done pulses %0d, required %0d", name, done_t.size(), n_done);
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      req_valid = '0;
      req_dev   = '0;
      req_reg   = '0;
      req_data  = '0;
      eng_auto  = 1'b1;
      nack_en   = 1'b0;
      nack_val  = 8'h00;
      tick(3);
      vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
      vec++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done); end
      vec++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", err); end
      vec++; if (done_id !== 3'd0) begin errs++; $display("FAIL rst_done_id: got %0d want 0", done_id); end
      vec++; if (eng_ready !== 1'b0) begin errs++; $display("FAIL rst_eng_ready: got %b want 0", eng_ready); end
      vec++; if (eng_data !== 8'hFF) begin errs++; $display("FAIL rst_eng_data: got %h want ff", eng_data); end
      rst_n = 1'b1;
      tick(1);
      clear_logs();
   endtask

   task automatic test_single_write;
      apply_reset();
      req_dev[6:0]  = 7'h50;
      req_reg[7:0]  = 8'h10;
      req_data[7:0] = 8'hA5;
      req_valid[0]  = 1'b1;
      wait_done(1, 200, "t1_done");
      tick(4);
      vec++; if (byte_log.size() != 3) begin errs++; $display("FAIL t1_eng_ready_cnt: got %0d want 3", byte_log.size()); end
      vec++; if (byte_log[0] !== 8'hA0) begin errs++; $display("FAIL t1_byte0: got %h want a0", byte_log[0]); end
      vec++; if (byte_log[1] !== 8'h10) begin errs++; $display("FAIL t1_byte1: got %h want 10", byte_log[1]); end
      vec++; if (byte_log[2] !== 8'hA5) begin errs++; $display("FAIL t1_byte2: got %h want a5", byte_log[2]); end
      vec++; if (done_t.size() != 1) begin errs++; $display("FAIL t1_done_cnt: got %0d want 1", done_t.size()); end
      vec++; if (err_log[0] !== 1'b0) begin errs++; $display("FAIL t1_err: got %b want 0", err_log[0]); end
      vec++; if (id_log[0] !== 3'd0) begin errs++; $display("FAIL t1_done_id: got %0d want 0", id_log[0]); end
      vec++; if (gnt_log[0] !== 2'b01) begin errs++; $display("FAIL t1_grant: got %b want 01", gnt_log[0]); end
      vec++; if ((er_t[0] - gnt_t[0]) != 10) begin errs++; $display("FAIL t1_ready_to_load: got %0d want 10", er_t[0] - gnt_t[0]); end
      vec++; if ((done_t[0] - rise_t) != 20) begin errs++; $display("FAIL t1_done_latency: got %0d want 20", done_t[0] - rise_t); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_b [6];
      exp_b = '{8'h42, 8'h01, 8'h11, 8'h44, 8'h02, 8'h22};
      apply_reset();
      req_dev   = {7'h22, 7'h21};
      req_reg   = {8'h02, 8'h01};
      req_data  = {8'h22, 8'h11};
      req_valid = 2'b11;
      wait_done(2, 400, "t2_done");
      tick(4);
      vec++; if (gnt_log.size() != 2) begin errs++; $display("FAIL t2_grant_cnt: got %0d want 2", gnt_log.size()); end
      vec++; if (gnt_log[0] !== 2'b01) begin errs++; $display("FAIL t2_grant0: got %b want 01", gnt_log[0]); end
      vec++; if (gnt_log[1] !== 2'b10) begin errs++; $display("FAIL t2_grant1: got %b want 10", gnt_log[1]); end
      vec++; if (!(gnt_t[1] > done_t[0])) begin errs++; $display("FAIL t2_serialised: grant1 at %0d, done0 at %0d, need grant after done", gnt_t[1], done_t[0]); end
      vec++; if (id_log[0] !== 3'd0) begin errs++; $display("FAIL t2_id0: got %0d want 0", id_log[0]); end
      vec++; if (id_log[1] !== 3'd1) begin errs++; $display("FAIL t2_id1: got %0d want 1", id_log[1]); end
      vec++; if ({err_log[0], err_log[1]} !== 2'b00) begin errs++; $display("FAIL t2_err: got %b%b want 00", err_log[0], err_log[1]); end
      vec++; if (byte_log.size() != 6) begin errs++; $display("FAIL t2_byte_cnt: got %0d want 6", byte_log.size()); end
      for (int i = 0; i < 6; i++) begin
         vec++;
         if (byte_log[i] !== exp_b[i]) begin
            errs++;
            $display("FAIL t2_byte%0d: got %h want %h", i, byte_log[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_nack;
      apply_reset();
      nack_en       = 1'b1;
      nack_val      = 8'hA0;
      req_dev[6:0]  = 7'h50;
      req_reg[7:0]  = 8'h10;
      req_data[7:0] = 8'hA5;
      req_valid[0]  = 1'b1;
      wait_done(1, 200, "t3_done");
      tick(6);
      vec++; if (byte_log.size() != 1) begin errs++; $display("FAIL t3_eng_ready_cnt: got %0d want 1", byte_log.size()); end
      vec++; if (err_log[0] !== 1'b1) begin errs++; $display("FAIL t3_err: got %b want 1", err_log[0]); end
      vec++; if (id_log[0] !== 3'd0) begin errs++; $display("FAIL t3_id: got %0d want 0", id_log[0]); end
      nack_en = 1'b0;
      clear_logs();
      req_dev[13:7]   = 7'h33;
      req_reg[15:8]   = 8'h44;
      req_data[15:8]  = 8'h55;
      req_valid[1]    = 1'b1;
      wait_done(1, 200, "t3_next_done");
      tick(4);
      vec++; if (gnt_log[0] !== 2'b10) begin errs++; $display("FAIL t3_next_grant: got %b want 10", gnt_log[0]); end
      vec++; if (err_log[0] !== 1'b0) begin errs++; $display("FAIL t3_next_err: got %b want 0", err_log[0]); end
      vec++; if (id_log[0] !== 3'd1) begin errs++; $display("FAIL t3_next_id: got %0d want 1", id_log[0]); end
      vec++; if (byte_log.size() != 3) begin errs++; $display("FAIL t3_next_byte_cnt: got %0d want 3", byte_log.size()); end
      vec++; if (byte_log[0] !== 8'h66) begin errs++; $display("FAIL t3_next_byte0: got %h want 66", byte_log[0]); end
      vec++; if (byte_log[2] !== 8'h55) begin errs++; $display("FAIL t3_next_byte2: got %h want 55", byte_log[2]); end
   endtask

   task automatic test_timeout;
      logic held_bad;
      int   k;
      held_bad = 1'b0;
      apply_reset();
      eng_auto      = 1'b0;
      req_dev[6:0]  = 7'h50;
      req_reg[7:0]  = 8'h10;
      req_data[7:0] = 8'hA5;
      req_valid[0]  = 1'b1;
      k = 0;
      while (done_t.size() == 0 && k < 300) begin
         tick(1);
         if (er_t.size() > 0 && eng_data !== 8'hA0) held_bad = 1'b1;
         k++;
      end
      tick(3);
      vec++; if (done_t.size() != 1) begin errs++; $display("FAIL t4_done_cnt: got %0d want 1", done_t.size()); end
      vec++; if (err_log[0] !== 1'b1) begin errs++; $display("FAIL t4_err: got %b want 1", err_log[0]); end
      vec++; if ((done_t[0] - er_t[0]) != 640) begin errs++; $display("FAIL t4_timeout_len: got %0d want 640", done_t[0] - er_t[0]); end
      vec++; if (held_bad !== 1'b0) begin errs++; $display("FAIL t4_data_held: got changed=%b want 0", held_bad); end
      vec++; if (byte_log.size() != 1) begin errs++; $display("FAIL t4_eng_ready_cnt: got %0d want 1", byte_log.size()); end
   endtask

   task automatic test_stuck_done;
      int k;
      apply_reset();
      eng_auto = 1'b0;
      eng_done = 1'b1;
      tick(2);
      req_dev[6:0]  = 7'h50;
      req_reg[7:0]  = 8'h10;
      req_data[7:0] = 8'hA5;
      req_valid[0]  = 1'b1;
      k = 0;
      while (byte_log.size() == 0 && k < 20) begin
         tick(1);
         k++;
      end
      vec++; if (byte_log.size() != 1) begin errs++; $display("FAIL t5_first_load: got %0d loads want 1", byte_log.size()); end
      tick(5);
      vec++; if (byte_log.size() != 1) begin errs++; $display("FAIL t5_stuck_no_advance: got %0d loads want 1", byte_log.size()); end
      eng_done = 1'b0;
      tick(2);
      eng_done = 1'b1;
      tick(2);
      eng_done = 1'b0;
      tick(6);
      vec++; if (byte_log.size() != 2) begin errs++; $display("FAIL t5_one_advance: got %0d loads want 2", byte_log.size()); end
      vec++; if (byte_log[1] !== 8'h10) begin errs++; $display("FAIL t5_byte1: got %h want 10", byte_log[1]); end
      vec++; if (done_t.size() != 0) begin errs++; $display("FAIL t5_no_done: got %0d done want 0", done_t.size()); end
   endtask

   task automatic test_reset_mid;
      int k;
      apply_reset();
      req_dev   = {7'h33, 7'h50};
      req_reg   = {8'h44, 8'h10};
      req_data  = {8'h55, 8'hA5};
      req_valid = 2'b11;
      k = 0;
      while (byte_log.size() < 2 && k < 100) begin
         tick(1);
         k++;
      end
      vec++; if (byte_log.size() != 2) begin errs++; $display("FAIL t6_reach_byte1: got %0d loads want 2", byte_log.size()); end
      tick(1);
      #1;
      rst_n = 1'b0;
      #1;
      vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL t6_req_ready: got %b want 00", req_ready); end
      vec++; if (done !== 1'b0) begin errs++; $display("FAIL t6_done: got %b want 0", done); end
      vec++; if (err !== 1'b0) begin errs++; $display("FAIL t6_err: got %b want 0", err); end
      vec++; if (done_id !== 3'd0) begin errs++; $display("FAIL t6_done_id: got %0d want 0", done_id); end
      vec++; if (eng_ready !== 1'b0) begin errs++; $display("FAIL t6_eng_ready: got %b want 0", eng_ready); end
      vec++; if (eng_data !== 8'hFF) begin errs++; $display("FAIL t6_eng_data: got %h want ff", eng_data); end
      tick(6);
      vec++; if (done_t.size() != 0) begin errs++; $display("FAIL t6_no_done: got %0d done want 0", done_t.size()); end
      clear_logs();
      rst_n = 1'b1;
      wait_done(1, 200, "t6_after_done");
      tick(4);
      vec++; if (gnt_log[0] !== 2'b10) begin errs++; $display("FAIL t6_grant: got %b want 10", gnt_log[0]); end
      vec++; if (id_log[0] !== 3'd1) begin errs++; $display("FAIL t6_id: got %0d want 1", id_log[0]); end
      vec++; if (err_log[0] !== 1'b0) begin errs++; $display("FAIL t6_err_after: got %b want 0", err_log[0]); end
      vec++; if (byte_log[0] !== 8'h66) begin errs++; $display("FAIL t6_byte0: got %h want 66", byte_log[0]); end
   endtask

   initial begin
      vec       = 0;
      errs      = 0;
      rise_t    = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_dev   = '0;
      req_reg   = '0;
      req_data  = '0;
      eng_auto  = 1'b1;
      nack_en   = 1'b0;
      nack_val  = 8'h00;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_nack();
      test_timeout();
      test_stuck_done();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
